hint_pack: RTL and testbench

Signer-side hint encoder: consumes the per-coefficient MakeHint bit stream for all K polynomials and packs it into the Dilithium signature hint field. The field holds omega position bytes followed by K cumulative-count bytes. The block emits that field as W-bit words in exactly the byte order and padding the verifier's hint receiver consumes. It also raises `reject_o` when the hint weight exceeds omega, so the signing loop can restart.

---
 rtl/hint_pack.sv | 251 +++++++++++++++++++++++++
 tb/tb_hint_pack.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hint_pack.sv
// hint_pack: signer-side hint encoder.
// Collects the MakeHint bit stream for K polynomials, builds the hint field
// (omega position bytes followed by K cumulative-count bytes) in a byte
// buffer, and streams it out as W-bit words, byte 0 in the MSBs.
// Raises reject_o instead of emitting when the hint weight exceeds omega.
//
// Handshakes: a beat transfers on any rising clk edge where its valid and
// ready are both high (hint_valid_i/hint_ready_i on the input side,
// valid_o/ready_o on the output side). Valid never depends on ready, and
// do_o holds its value while valid_o is high and ready_o is low.
//
// The output port carrying the packed word is named do_o because "do" is a
// reserved word in SystemVerilog.
module hint_pack #(
    parameter int OUTPUT_W = 4,
    parameter int W        = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          sec_lvl,
    input  logic [OUTPUT_W-1:0] hint_i,
    input  logic                hint_valid_i,
    output logic                hint_ready_i,
    output logic [W-1:0]        do_o,
    output logic                valid_o,
    input  logic                ready_o,
    output logic                reject_o,
    output logic                done_o,
    output logic [1:0]          state_o
);

    localparam int BPW            = W / 8;
    localparam int BEATS_PER_POLY = 256 / OUTPUT_W;
    localparam int BEAT_LOG       = $clog2(BEATS_PER_POLY);
    localparam int MAX_L          = 84;
    localparam int MAX_WORDS      = (MAX_L + BPW - 1) / BPW;
    localparam int BUF_BYTES      = MAX_WORDS * BPW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_n;

    logic [2:0]  lvl_q;
    logic [7:0]  count_q;
    logic [10:0] beat_q;
    logic [3:0]  wctr_q;
    logic        ovf_q;
    logic        rej_q;
    logic [7:0]  buf_q [BUF_BYTES];

    // Parameter set derived from the level latched at start.
    logic [3:0]  k_cfg;
    logic [7:0]  omega_cfg;
    logic [7:0]  l_cfg;
    logic [7:0]  nw_full;
    logic [3:0]  nw_cfg;
    logic [10:0] last_beat;

    // Per-beat datapath.
    logic                hs_in;
    logic                hs_out;
    logic                beat_last;
    logic                poly_last;
    logic [7:0]          cnt_idx;
    logic [7:0]          pop;
    logic [7:0]          slot [OUTPUT_W];
    logic [OUTPUT_W-1:0] slot_en;
    logic [7:0]          pos  [OUTPUT_W];
    logic [8:0]          sum;
    logic                ovf_now;
    logic                ovf_nx;
    logic [7:0]          count_nx;
    logic                emit_last;

    // Decode the latched level into K, omega, field length and word count.
    always_comb begin
        k_cfg     = 4'd8;
        omega_cfg = 8'd75;
        case (lvl_q)
            3'd2: begin
                k_cfg     = 4'd4;
                omega_cfg = 8'd80;
            end
            3'd3: begin
                k_cfg     = 4'd6;
                omega_cfg = 8'd55;
            end
            default: begin
                k_cfg     = 4'd8;
                omega_cfg = 8'd75;
            end
        endcase
        l_cfg     = omega_cfg + {4'd0, k_cfg};
        nw_full   = (l_cfg + 8'(BPW - 1)) / 8'(BPW);
        nw_cfg    = nw_full[3:0];
        last_beat = 11'(k_cfg) * 11'(BEATS_PER_POLY) - 11'd1;
    end

    // Handshake and beat-position decode.
    always_comb begin
        hs_in     = (state_q == S_COLLECT) && hint_valid_i;
        hs_out    = (state_q == S_EMIT) && ready_o;
        beat_last = (beat_q == last_beat);
        poly_last = &beat_q[BEAT_LOG-1:0];
        cnt_idx   = omega_cfg + 8'(beat_q[10:BEAT_LOG]);
        emit_last = hs_out && (wctr_q == nw_cfg - 4'd1);
    end

    // Each set lane takes the next free position slot: count plus the
    // number of set lanes below it. Slots at or above omega are dropped,
    // which also silences every write once the count has saturated.
    always_comb begin
        pop = '0;
        for (int n = 0; n < OUTPUT_W; n++) begin
            slot[n]    = count_q + pop;
            slot_en[n] = hint_i[n] && (slot[n] < omega_cfg);
            pos[n]     = 8'(beat_q[BEAT_LOG-1:0]) * 8'(OUTPUT_W) + 8'(n);
            pop        = pop + {7'd0, hint_i[n]};
        end
    end

    // Running weight with saturation at omega+1 and sticky overflow.
    always_comb begin
        sum      = {1'b0, count_q} + {1'b0, pop};
        ovf_now  = (sum > {1'b0, omega_cfg});
        ovf_nx   = ovf_q | ovf_now;
        count_nx = ovf_now ? (omega_cfg + 8'd1) : sum[7:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (hs_in && beat_last) begin
                    state_n = ovf_nx ? S_IDLE : S_EMIT;
                end
            end
            S_EMIT: begin
                if (emit_last) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs: handshake flags from state, packed word muxed from the buffer.
    always_comb begin
        hint_ready_i = (state_q == S_COLLECT);
        valid_o      = (state_q == S_EMIT);
        reject_o     = rej_q;
        done_o       = rej_q | emit_last;
        state_o      = state_q;
        do_o         = '0;
        if (state_q == S_EMIT) begin
            for (int w = 0; w < MAX_WORDS; w++) begin
                if (wctr_q == 4'(w)) begin
                    for (int k = 0; k < BPW; k++) begin
                        do_o[W-1-8*k -: 8] = buf_q[w*BPW+k];
                    end
                end
            end
        end
    end

    // Counters, latched level, overflow flag and the reject pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q   <= 3'd0;
            count_q <= 8'd0;
            beat_q  <= 11'd0;
            wctr_q  <= 4'd0;
            ovf_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            rej_q <= hs_in && beat_last && ovf_nx;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        lvl_q   <= sec_lvl;
                        count_q <= 8'd0;
                        beat_q  <= 11'd0;
                        wctr_q  <= 4'd0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (hs_in) begin
                        count_q <= count_nx;
                        ovf_q   <= ovf_nx;
                        beat_q  <= beat_q + 11'd1;
                    end
                end
                S_EMIT: begin
                    if (hs_out) begin
                        wctr_q <= emit_last ? 4'd0 : wctr_q + 4'd1;
                    end
                end
                default: begin
                    wctr_q <= 4'd0;
                end
            endcase
        end
    end

    // Field buffer: cleared on start, position and count bytes written per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < BUF_BYTES; b++) begin
                buf_q[b] <= 8'd0;
            end
        end else if ((state_q == S_IDLE) && start) begin
            for (int b = 0; b < BUF_BYTES; b++) begin
                buf_q[b] <= 8'd0;
            end
        end else if (hs_in) begin
            for (int b = 0; b < BUF_BYTES; b++) begin
                for (int n = 0; n < OUTPUT_W; n++) begin
                    if (slot_en[n] && (slot[n] == 8'(b))) begin
                        buf_q[b] <= pos[n];
                    end
                end
                if (poly_last && !ovf_nx && (cnt_idx == 8'(b))) begin
                    buf_q[b] <= count_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_hint_pack.sv
// Testbench for hint_pack: directed vector table, randomized hint sets with
// back-pressure checked against a list-based model of the hint field, the
// omega boundary, and a reset during emission.
module tb_hint_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  sec_lvl = 3'd0;
    logic [3:0]  hint_i = 4'd0;
    logic        hint_valid_i = 1'b0;
    logic        hint_ready_i;
    logic [63:0] do_o;
    logic        valid_o;
    logic        ready_o = 1'b0;
    logic        reject_o;
    logic        done_o;
    logic [1:0]  state_o;

    always #5 clk = ~clk;

    hint_pack #(.OUTPUT_W(4), .W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sec_lvl      (sec_lvl),
        .hint_i       (hint_i),
        .hint_valid_i (hint_valid_i),
        .hint_ready_i (hint_ready_i),
        .do_o         (do_o),
        .valid_o      (valid_o),
        .ready_o      (ready_o),
        .reject_o     (reject_o),
        .done_o       (done_o),
        .state_o      (state_o)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    bit          hb [8][256];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    bit          exp_reject;

    typedef struct {
        logic [2:0]  lvl;
        int          pat;
        int          nw;
        logic [63:0] w0;
        logic [63:0] wl;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic int k_of(input logic [2:0] lvl);
        if (lvl == 3'd2) return 4;
        if (lvl == 3'd3) return 6;
        return 8;
    endfunction

    function automatic int omega_of(input logic [2:0] lvl);
        if (lvl == 3'd2) return 80;
        if (lvl == 3'd3) return 55;
        return 75;
    endfunction

    task automatic clear_hints();
        for (int j = 0; j < 8; j++)
            for (int c = 0; c < 256; c++)
                hb[j][c] = 1'b0;
    endtask

    task automatic set_random(input logic [2:0] lvl, input int weight);
        int kk;
        int placed;
        int j;
        int c;
        kk = k_of(lvl);
        placed = 0;
        clear_hints();
        while (placed < weight) begin
            j = $urandom_range(0, kk - 1);
            c = $urandom_range(0, 255);
            if (!hb[j][c]) begin
                hb[j][c] = 1'b1;
                placed++;
            end
        end
    endtask

    // Reference: list the set coefficients in stream order, then lay out
    // positions, cumulative counts and zero padding as a byte string.
    task automatic build_expected(input logic [2:0] lvl);
        int          kk;
        int          om;
        int          nw;
        int          pos_q[$];
        int          cum [8];
        logic [7:0]  bytes [88];
        logic [63:0] word;
        kk = k_of(lvl);
        om = omega_of(lvl);
        exp_q.delete();
        for (int i = 0; i < 88; i++) bytes[i] = 8'd0;
        for (int j = 0; j < kk; j++) begin
            for (int c = 0; c < 256; c++)
                if (hb[j][c]) pos_q.push_back(c);
            cum[j] = pos_q.size();
        end
        exp_reject = (pos_q.size() > om);
        if (!exp_reject) begin
            for (int i = 0; i < pos_q.size(); i++) bytes[i] = 8'(pos_q[i]);
            for (int j = 0; j < kk; j++) bytes[om+j] = 8'(cum[j]);
            nw = (om + kk + 7) / 8;
            for (int w = 0; w < nw; w++) begin
                word = '0;
                for (int b = 0; b < 8; b++) word[63-8*b -: 8] = bytes[w*8+b];
                exp_q.push_back(word);
            end
        end
    endtask

    // One encoding: start, stream all beats with random gaps, then either
    // check the reject pulse or collect words under random back-pressure.
    // abort_at > 0 pulls reset while word abort_at is being presented.
    task automatic run_enc(input logic [2:0] lvl, input int rdy_pct, input int abort_at);
        int          kk;
        int          beat;
        int          cyc;
        int          words;
        int          nw_exp;
        bit          hs;
        bit          stalled;
        logic [63:0] prev_do;
        kk = k_of(lvl);
        beat = 0;
        cyc = 0;
        words = 0;
        stalled = 1'b0;
        prev_do = '0;
        got_q.delete();

        @(negedge clk);
        start = 1'b1;
        sec_lvl = lvl;
        hint_valid_i = 1'b1;
        hint_i = 4'hF;
        #1;
        chk("idle_not_ready", hint_ready_i, 1'b0);
        @(negedge clk);
        start = 1'b0;
        sec_lvl = 3'($urandom_range(0, 7));
        #1;
        chk("ready_after_start", hint_ready_i, 1'b1);

        while (beat < kk * 64 && cyc < 4000) begin
            hint_valid_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) hint_i[i] = hb[beat / 64][(beat % 64) * 4 + i];
            #1;
            hs = hint_valid_i && hint_ready_i;
            @(negedge clk);
            if (hs) beat++;
            cyc++;
        end
        hint_valid_i = 1'b0;
        hint_i = 4'd0;
        chk("collect_timeout", 64'(cyc >= 4000), 0);
        #1;

        if (exp_reject) begin
            chk("reject_pulse", reject_o, 1'b1);
            chk("reject_done", done_o, 1'b1);
            chk("reject_valid", valid_o, 1'b0);
            chk("reject_ready", hint_ready_i, 1'b0);
            @(negedge clk);
            #1;
            chk("reject_one_cycle", reject_o, 1'b0);
            chk("reject_done_one_cycle", done_o, 1'b0);
            repeat (3) begin
                chk("no_valid_after_reject", valid_o, 1'b0);
                @(negedge clk);
                #1;
            end
            return;
        end

        chk("valid_after_last_beat", valid_o, 1'b1);
        chk("no_reject", reject_o, 1'b0);
        chk("ready_low_in_emit", hint_ready_i, 1'b0);
        nw_exp = exp_q.size();
        cyc = 0;
        while (words < nw_exp && cyc < 2000) begin
            ready_o = ($urandom_range(1, 100) <= rdy_pct);
            #1;
            if (stalled) chk("do_stable", do_o, prev_do);
            chk("valid_in_emit", valid_o, 1'b1);
            if (ready_o) begin
                got_q.push_back(do_o);
                chk("done_on_handshake", done_o, 64'(words == nw_exp - 1));
                words++;
            end else begin
                chk("done_low_stall", done_o, 1'b0);
            end
            stalled = !ready_o;
            prev_do = do_o;
            @(negedge clk);
            cyc++;
            if (abort_at > 0 && words == abort_at) begin
                ready_o = 1'b0;
                #1;
                chk("pre_reset_valid", valid_o, 1'b1);
                rst = 1'b0;
                #1;
                chk("reset_valid", valid_o, 1'b0);
                chk("reset_do", do_o, 64'd0);
                chk("reset_done", done_o, 1'b0);
                chk("reset_ready", hint_ready_i, 1'b0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
        end
        ready_o = 1'b0;
        chk("emit_timeout", 64'(cyc >= 2000), 0);
        #1;
        chk("idle_after_emit", valid_o, 1'b0);
    endtask

    task automatic compare_words(input string name);
        chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk(name, got_q[i], exp_q[i]);
    endtask

    initial begin
        logic [2:0] lvl;
        int         wt;
        logic [2:0] lvls [4];
        lvls[0] = 3'd2;
        lvls[1] = 3'd3;
        lvls[2] = 3'd5;
        lvls[3] = 3'd7;

        vecs[0] = '{3'd2, 0, 11, 64'h0000000000000000, 64'h0000000000000000};
        vecs[1] = '{3'd2, 1, 11, 64'h05FF000000000000, 64'h0101010200000000};
        vecs[2] = '{3'd2, 2, 11, 64'h0001020300000000, 64'h0404040400000000};

        // Reset state.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hint_ready", hint_ready_i, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_do", do_o, 64'd0);
        chk("rst_reject", reject_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 3; v++) begin
            clear_hints();
            if (vecs[v].pat == 1) begin
                hb[0][5] = 1'b1;
                hb[3][255] = 1'b1;
            end else if (vecs[v].pat == 2) begin
                for (int i = 0; i < 4; i++) hb[0][i] = 1'b1;
            end
            build_expected(vecs[v].lvl);
            run_enc(vecs[v].lvl, 100, 0);
            chk("vec_nw", 64'(got_q.size()), 64'(vecs[v].nw));
            if (got_q.size() > 0) begin
                chk("vec_word0", got_q[0], vecs[v].w0);
                chk("vec_wordlast", got_q[got_q.size()-1], vecs[v].wl);
            end
            compare_words("vec_word");
        end

        // Level 3 at exactly omega.
        set_random(3'd3, 55);
        build_expected(3'd3);
        run_enc(3'd3, 70, 0);
        compare_words("l3_full_word");
        chk("l3_nw", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) begin
            chk("l3_byte60", 64'(got_q[7][31:24]), 64'h37);
            chk("l3_pad", 64'(got_q[7][23:0]), 64'd0);
        end

        // Level 3 one past omega: reject.
        set_random(3'd3, 56);
        build_expected(3'd3);
        run_enc(3'd3, 100, 0);

        // Level 5 random weights with back-pressure.
        repeat (4) begin
            set_random(3'd5, $urandom_range(0, 75));
            build_expected(3'd5);
            run_enc(3'd5, 50, 0);
            compare_words("l5_rand_word");
        end
        set_random(3'd5, 75);
        build_expected(3'd5);
        run_enc(3'd5, 40, 0);
        compare_words("l5_max_word");
        set_random(3'd5, 76);
        build_expected(3'd5);
        run_enc(3'd5, 100, 0);

        // Mixed levels, weights straddling omega.
        repeat (3) begin
            lvl = lvls[$urandom_range(0, 3)];
            wt = $urandom_range(0, omega_of(lvl) + 3);
            set_random(lvl, wt);
            build_expected(lvl);
            run_enc(lvl, 60, 0);
            compare_words("mix_word");
        end

        // Reset during word 3, then a clean full encoding.
        set_random(3'd2, 20);
        build_expected(3'd2);
        run_enc(3'd2, 100, 3);
        run_enc(3'd2, 60, 0);
        compare_words("post_reset_word");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
